spi_ram_wrapper: RTL and testbench



---
 rtl/spi_ram_wrapper.sv | 132 +++++++++++++
 tb/tb_spi_ram_wrapper.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_wrapper.sv
// SPI slave taking 10-bit command frames into an 8-bit scratchpad RAM (DUT_RAM); MISO byte starts 2 clocks after the read-data frame.
// No backpressure: frames are accepted at line rate. Define SPI_WR_ADDR_AUTOINC_EN to post-increment wr_addr after each data write.
module spi_ram_wrapper #(
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t     state;
  logic [9:0] din;
  logic [4:0] bit_cnt;
  logic       rx_valid;
  logic [6:0] tx_shift;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rd_addr_received;

  function automatic logic [AW-1:0] wrap(input logic [7:0] a);
    return AW'(32'(a) % MEM_DEPTH);
  endfunction

  // bit_cnt runs 0..10 for the frame; in READ_DATA it keeps going 11..19 to pace the MISO byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      din      <= '0;
      bit_cnt  <= '0;
      rx_valid <= 1'b0;
      tx_shift <= '0;
      MISO     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n && state != IDLE) begin
        state   <= IDLE;
        bit_cnt <= '0;
        MISO    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            MISO    <= 1'b0;
            if (!ss_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!MOSI)                  state <= WRITE;
            else if (!rd_addr_received) state <= READ_ADD;
            else                        state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt < 5'd10) begin
              din      <= {din[8:0], MOSI};
              bit_cnt  <= bit_cnt + 5'd1;
              rx_valid <= (bit_cnt == 5'd9);
            end else if (state != READ_DATA) begin
              state <= IDLE;
            end else if (bit_cnt == 5'd10) begin
              bit_cnt <= 5'd11;
            end else if (bit_cnt == 5'd11) begin
              // A frame that was not a read-data command never raises tx_valid
              if (tx_valid) begin
                MISO     <= tx_data[7];
                tx_shift <= tx_data[6:0];
                bit_cnt  <= 5'd12;
              end else begin
                state <= IDLE;
              end
            end else if (bit_cnt < 5'd19) begin
              MISO     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              bit_cnt  <= bit_cnt + 5'd1;
            end else begin
              MISO  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  if (1) begin : DUT_RAM
    logic [7:0] mem [0:MEM_DEPTH-1];
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;

    // Storage is left out of reset so it can be preloaded and survives a link reset
    always_ff @(posedge clk) begin
      if (rx_valid && din[9:8] == 2'b01) mem[wrap(wr_addr)] <= din[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_addr          <= '0;
        rd_addr          <= '0;
        rd_addr_received <= 1'b0;
        tx_valid         <= 1'b0;
        tx_data          <= '0;
      end else begin
        tx_valid <= 1'b0;
        if (rx_valid) begin
          case (din[9:8])
            2'b00: wr_addr <= din[7:0];
            2'b01: begin
`ifdef SPI_WR_ADDR_AUTOINC_EN
              wr_addr <= 8'((32'(wr_addr) + 32'd1) % MEM_DEPTH);
`endif
            end
            2'b10: begin
              rd_addr          <= din[7:0];
              rd_addr_received <= 1'b1;
            end
            default: begin
              tx_data          <= mem[wrap(rd_addr)];
              tx_valid         <= 1'b1;
              rd_addr_received <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Self-checking bench for spi_ram_wrapper: transaction-level memory model plus per-cycle MISO comparison.
module tb_spi_ram_wrapper;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;

  spi_ram_wrapper #(.MEM_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ss_n (ss_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic exp_miso = 1'b0;

  logic [7:0] model_mem [DEPTH];
  logic [7:0] m_wr = 8'h00;
  logic [7:0] m_rd = 8'h00;
  logic       m_rdrecv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MISO must track the expected serial stream on every cycle
  always @(negedge clk) begin
    checks++;
    if (MISO !== exp_miso) begin
      failures++;
      $display("FAIL miso_cycle t=%0t: got %b expected %b", $time, MISO, exp_miso);
    end
  end

  task automatic step(input logic mosi_bit);
    MOSI = mosi_bit;
    @(posedge clk);
    #1;
  endtask

  // IDLE->CHK edge, command-select edge, then ten frame bits MSB first
  task automatic send_bits(input logic chk, input logic [9:0] bits);
    step(1'($urandom));
    step(chk);
    for (int i = 9; i >= 0; i--) step(bits[i]);
  endtask

  task automatic frame(input logic chk, input logic [9:0] bits, output logic [7:0] got);
    logic       is_rd;
    logic [7:0] b;
    is_rd = chk && m_rdrecv && (bits[9:8] == 2'b11);
    b = model_mem[32'(m_rd) % DEPTH];
    got = '0;
    send_bits(chk, bits);
    step(1'($urandom));
    if (is_rd) begin
      for (int k = 7; k >= 0; k--) begin
        step(1'($urandom));
        exp_miso = b[k];
        got[k] = MISO;
      end
      step(1'($urandom));
      exp_miso = 1'b0;
    end
    case (bits[9:8])
      2'b00: m_wr = bits[7:0];
      2'b01: begin
        model_mem[32'(m_wr) % DEPTH] = bits[7:0];
`ifdef SPI_WR_ADDR_AUTOINC_EN
        m_wr = 8'((32'(m_wr) + 1) % DEPTH);
`endif
      end
      2'b10: begin
        m_rd = bits[7:0];
        m_rdrecv = 1'b1;
      end
      default: m_rdrecv = 1'b0;
    endcase
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s_mem%0h", tag, i), 32'(dut.DUT_RAM.mem[i]), 32'(model_mem[i]));
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] got;
    logic [7:0] b;
    logic [7:0] addr;

    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      dut.DUT_RAM.mem[i] <= v;
      model_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_miso", 32'(MISO), 32'h0);
    check("reset_rd_addr_received", 32'(dut.rd_addr_received), 32'h0);
    rst_n = 1'b1;
    step(1'b0);

    // Write address 01 then data F1, ss_n held low throughout
    ss_n = 1'b0;
    frame(1'b0, 10'b00_0000_0001, got);
    frame(1'b0, 10'b01_1111_0001, got);
    check("mem1_written", 32'(dut.DUT_RAM.mem[1]), 32'hF1);
    compare_mem("wr");

    // Read address 01 then read data -> F1 on MISO
    frame(1'b1, 10'b10_0000_0001, got);
    check("rdrecv_after_rdaddr", 32'(dut.rd_addr_received), 32'h1);
    frame(1'b1, {2'b11, 8'($urandom)}, got);
    check("read_byte_F1", 32'(got), 32'hF1);
    check("rdrecv_after_rddata", 32'(dut.rd_addr_received), 32'h0);

    // Preloaded word read back
    dut.DUT_RAM.mem[8'hAA] <= 8'h5C;
    model_mem[8'hAA] = 8'h5C;
    #1;
    frame(1'b1, {2'b10, 8'hAA}, got);
    frame(1'b1, {2'b11, 8'($urandom)}, got);
    check("read_byte_5C", 32'(got), 32'h5C);

    // Abort a data-write frame after 5 bits
    step(1'($urandom));
    step(1'b0);
    step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    ss_n = 1'b1;
    step(1'($urandom));
    step(1'($urandom));
    ss_n = 1'b0;
    compare_mem("abort");
    addr = m_wr;
    frame(1'b0, {2'b01, 8'h9E}, got);
    check("write_after_abort", 32'(dut.DUT_RAM.mem[addr]), 32'h9E);

    // Reset during the MISO shift-out
    dut.DUT_RAM.mem[8'h3C] <= 8'hFF;
    model_mem[8'h3C] = 8'hFF;
    #1;
    frame(1'b1, {2'b10, 8'h3C}, got);
    b = model_mem[8'h3C];
    send_bits(1'b1, {2'b11, 8'h00});
    step(1'($urandom));
    step(1'($urandom));
    exp_miso = b[7];
    step(1'($urandom));
    exp_miso = b[6];
    #1;
    exp_miso = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_miso_async", 32'(MISO), 32'h0);
    check("rst_rd_addr_received", 32'(dut.rd_addr_received), 32'h0);
    m_wr = 8'h00;
    m_rd = 8'h00;
    m_rdrecv = 1'b0;
    ss_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'($urandom));
    ss_n = 1'b0;
    frame(1'b0, {2'b01, 8'hC3}, got);
    check("wr_addr_reset_to_0", 32'(dut.DUT_RAM.mem[0]), 32'hC3);

    // Write address FF then two data writes
    frame(1'b0, {2'b00, 8'hFF}, got);
    frame(1'b0, {2'b01, 8'h11}, got);
    frame(1'b0, {2'b01, 8'h22}, got);
`ifdef SPI_WR_ADDR_AUTOINC_EN
    check("autoinc_memFF", 32'(dut.DUT_RAM.mem[8'hFF]), 32'h11);
    check("autoinc_mem00", 32'(dut.DUT_RAM.mem[8'h00]), 32'h22);
`else
    check("noinc_memFF", 32'(dut.DUT_RAM.mem[8'hFF]), 32'h22);
`endif
    compare_mem("inc");

    // Randomized consistent command stream with occasional deselect gaps
    for (int n = 0; n < 80; n++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ss_n = 1'b1;
        repeat ($urandom_range(1, 3)) step(1'($urandom));
        ss_n = 1'b0;
      end
      case ($urandom_range(0, 2))
        0: frame(1'b0, {2'b00, 4'h0, v[3:0]}, got);
        1: frame(1'b0, {2'b01, v}, got);
        default: begin
          if (m_rdrecv) frame(1'b1, {2'b11, v}, got);
          else          frame(1'b1, {2'b10, 4'h0, v[3:0]}, got);
        end
      endcase
    end
    check("rand_rd_addr_received", 32'(dut.rd_addr_received), 32'(m_rdrecv));
    compare_mem("rand");

    ss_n = 1'b1;
    step(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
